seg7_capture: RTL and testbench

Inverse of the hex-to-seven-segment path. It passively monitors the scanned display bus (active-low segments, active-low one-hot anodes) and recovers the 4-digit hex value actually being shown. The result is published one frame at a time, with per-digit valid/blank flags and a pattern-error pulse. It sits on the loopback of the display driver and feeds the on-board self-check and score-verify logic.

---
 rtl/seg7_pkg.sv | 52 +++++
 rtl/seg7_pattern_decode.sv | 28 ++
 rtl/seg7_capture.sv | 198 +++++++++++++++++++
 tb/tb_seg7_capture.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment capture path.
// Segment encodings are active-low with seg[0]=a ... seg[6]=g.
// SEG_LUT[n] is the pattern shown for hex value n.
// The ST_* values are the capture FSM states.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [15:0][6:0] SEG_LUT = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  // FSM state encoding
  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  // True when exactly one active-low anode is asserted.
  function automatic logic an_onehot(input logic [NUM_DIGITS-1:0] an);
    return ($countones(~an) == 1);
  endfunction

  // Position of the (single) low anode.
  function automatic logic [1:0] an_index(input logic [NUM_DIGITS-1:0] an);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-seven-segment table.
// Ports:
//   seg    - active-low segment pattern (seg[0]=a ... seg[6]=g)
//   nibble - hex value of a legal pattern, 0 otherwise
//   legal  - pattern matches one of the 16 hex glyphs
//   blank  - all segments off
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    nibble = '0;
    legal  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_LUT[i]) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
    blank = (seg == SEG_BLANK);
  end

endmodule

// File: rtl/seg7_capture.sv
// Passive monitor of a scanned 4-digit seven-segment bus. It recovers the hex value
// being shown and publishes it one full frame at a time.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   seg, an     - active-low segments and active-low one-hot anodes
//   digits      - committed nibbles, digit i at [4i+3:4i]
//   digit_valid - committed digit decoded to a legal glyph
//   digit_blank - committed digit had all segments off
//   frame_done  - one-cycle pulse on commit
//   pat_err     - one-cycle pulse on capture of an illegal, non-blank pattern
//   stale       - set by timeout, cleared by the next commit
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  digit_blank,
  output logic        frame_done,
  output logic        pat_err,
  output logic        stale
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [6:0]  seg_q;
  logic [3:0]  an_q;
  logic [10:0] prev_q;
  logic [1:0]  state_q, state_d;
  logic [7:0]  stable_q, stable_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic [15:0] sh_nib_q, sh_nib_d;
  logic [3:0]  sh_valid_q, sh_valid_d;
  logic [3:0]  sh_blank_q, sh_blank_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  valid_q, valid_d;
  logic [3:0]  blank_q, blank_d;
  logic        frame_done_q, frame_done_d;
  logic        pat_err_q, pat_err_d;
  logic        stale_q, stale_d;

  logic [3:0]  dec_nibble;
  logic        dec_legal;
  logic        dec_blank;
  logic        onehot;
  logic        changed;
  logic [1:0]  idx;
  logic        capture;
  logic        commit;
  logic        timeout_hit;

  seg7_pattern_decode u_decode (
    .seg    (seg_q),
    .nibble (dec_nibble),
    .legal  (dec_legal),
    .blank  (dec_blank)
  );

  assign onehot  = an_onehot(an_q);
  assign changed = ({an_q, seg_q} != prev_q);
  assign idx     = an_index(an_q);

  // Settle FSM: a digit is captured once {an_q, seg_q} has been unchanged for
  // SETTLE_CYCLES consecutive edges while a single anode is active.
  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    capture  = 1'b0;
    case (state_q)
      ST_WAIT: begin
        stable_d = '0;
        if (onehot) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!onehot) begin
          state_d  = ST_WAIT;
          stable_d = '0;
        end else if (changed) begin
          stable_d = '0;
        end else if (stable_q == 8'(SETTLE_CYCLES - 1)) begin
          capture  = 1'b1;
          state_d  = ST_HOLD;
          stable_d = '0;
        end else begin
          stable_d = stable_q + 8'd1;
        end
      end
      ST_HOLD: begin
        stable_d = '0;
        if (!onehot) state_d = ST_WAIT;
        else if (changed) state_d = ST_SETTLE;
      end
      default: begin
        state_d  = ST_WAIT;
        stable_d = '0;
      end
    endcase
  end

  assign commit      = (seen_q == {NUM_DIGITS{1'b1}});
  assign timeout_hit = !capture && (to_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    sh_nib_d   = sh_nib_q;
    sh_valid_d = sh_valid_q;
    sh_blank_d = sh_blank_q;
    seen_d     = seen_q;
    digits_d   = digits_q;
    valid_d    = valid_q;
    blank_d    = blank_q;
    stale_d    = stale_q;
    pat_err_d  = capture && !dec_legal && !dec_blank;
    frame_done_d = commit;

    if (capture) begin
      to_d = '0;
    end else if (to_q == TO_W'(TIMEOUT_CYCLES)) begin
      to_d = to_q;
    end else begin
      to_d = to_q + 1'b1;
    end

    if (timeout_hit) begin
      valid_d = '0;
      seen_d  = '0;
      stale_d = 1'b1;
    end

    if (commit) begin
      digits_d = sh_nib_q;
      valid_d  = sh_valid_q;
      blank_d  = sh_blank_q;
      seen_d   = '0;
      stale_d  = 1'b0;
    end

    // Applied after the commit clear so a coincident capture keeps its seen bit.
    if (capture) begin
      sh_nib_d[{idx, 2'b00} +: 4] = dec_legal ? dec_nibble : 4'h0;
      sh_valid_d[idx] = dec_legal;
      sh_blank_d[idx] = dec_blank;
      seen_d[idx]     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q        <= SEG_BLANK;
      an_q         <= 4'hF;
      prev_q       <= {4'hF, SEG_BLANK};
      state_q      <= ST_WAIT;
      stable_q     <= '0;
      to_q         <= '0;
      seen_q       <= '0;
      sh_nib_q     <= '0;
      sh_valid_q   <= '0;
      sh_blank_q   <= '0;
      digits_q     <= '0;
      valid_q      <= '0;
      blank_q      <= '0;
      frame_done_q <= 1'b0;
      pat_err_q    <= 1'b0;
      stale_q      <= 1'b0;
    end else begin
      seg_q        <= seg;
      an_q         <= an;
      prev_q       <= {an_q, seg_q};
      state_q      <= state_d;
      stable_q     <= stable_d;
      to_q         <= to_d;
      seen_q       <= seen_d;
      sh_nib_q     <= sh_nib_d;
      sh_valid_q   <= sh_valid_d;
      sh_blank_q   <= sh_blank_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
      pat_err_q    <= pat_err_d;
      stale_q      <= stale_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign digit_blank = blank_q;
  assign frame_done  = frame_done_q;
  assign pat_err     = pat_err_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: stimulus pushes expected frames, a negedge
// monitor pops and compares on every frame_done.
module tb_seg7_capture;

  localparam int unsigned SETTLE  = 4;
  localparam int unsigned TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic [3:0]  digit_blank;
  logic        frame_done;
  logic        pat_err;
  logic        stale;

  seg7_capture #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .an          (an),
    .digits      (digits),
    .digit_valid (digit_valid),
    .digit_blank (digit_blank),
    .frame_done  (frame_done),
    .pat_err     (pat_err),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  v;
    logic [3:0]  b;
  } frame_t;

  frame_t exp_q[$];
  frame_t mon_e;
  int errors = 0;
  int checks = 0;
  int frames_seen = 0;
  int pat_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares each committed frame against the next expected one.
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      frames_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_frame_done", 32'(frame_done), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("frame_digits", 32'(digits), 32'(mon_e.d));
        check("frame_valid", 32'(digit_valid), 32'(mon_e.v));
        check("frame_blank", 32'(digit_blank), 32'(mon_e.b));
        check("frame_stale", 32'(stale), 32'd0);
      end
    end
    if (pat_err === 1'b1) pat_cycles++;
  end

  task automatic scan(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    scan(4'hE, s0, 8);
    scan(4'hD, s1, 8);
    scan(4'hB, s2, 8);
    scan(4'h7, s3, 8);
    scan(4'hF, 7'h7F, 4);
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] v, input logic [3:0] b);
    frame_t e;
    e.d = d;
    e.v = v;
    e.b = b;
    exp_q.push_back(e);
  endtask

  initial begin
    int f0;
    int p0;
    rst_n = 1'b0;
    an    = 4'hF;
    seg   = 7'h7F;
    repeat (4) @(negedge clk);
    check("rst_digits", 32'(digits), 32'd0);
    check("rst_valid", 32'(digit_valid), 32'd0);
    check("rst_blank", 32'(digit_blank), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_pat_err", 32'(pat_err), 32'd0);
    check("rst_stale", 32'(stale), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full frame: 0,1,A,8
    f0 = frames_seen;
    push(16'h8A10, 4'hF, 4'h0);
    frame(7'h40, 7'h79, 7'h08, 7'h00);
    check("full_frame_count", 32'(frames_seen - f0), 32'd1);

    // Glitching seg on digit 0 must not capture; then a settled 1 does.
    f0 = frames_seen;
    for (int i = 0; i < 8; i++) scan(4'hE, (i % 2 == 1) ? 7'h79 : 7'h40, 2);
    check("glitch_no_frame", 32'(frames_seen - f0), 32'd0);
    push(16'h4321, 4'hF, 4'h0);
    scan(4'hE, 7'h79, 8);
    scan(4'hD, 7'h24, 8);
    scan(4'hB, 7'h30, 8);
    scan(4'h7, 7'h19, 8);
    scan(4'hF, 7'h7F, 4);
    check("glitch_frame_count", 32'(frames_seen - f0), 32'd1);

    // Illegal pattern on digit 2
    p0 = pat_cycles;
    push(16'h7065, 4'hB, 4'h0);
    frame(7'h12, 7'h02, 7'h7E, 7'h78);
    check("illegal_pat_err_cycles", 32'(pat_cycles - p0), 32'd1);

    // Blank digit 3
    push(16'h0CB9, 4'h7, 4'h8);
    frame(7'h18, 7'h03, 7'h46, 7'h7F);

    // Timeout and recovery
    push(16'h8FED, 4'hF, 4'h0);
    frame(7'h21, 7'h06, 7'h0E, 7'h00);
    scan(4'hF, 7'h7F, 36);
    check("pre_timeout_stale", 32'(stale), 32'd0);
    check("pre_timeout_valid", 32'(digit_valid), 32'hF);
    scan(4'hF, 7'h7F, 34);
    check("timeout_stale", 32'(stale), 32'd1);
    check("timeout_valid", 32'(digit_valid), 32'd0);
    check("timeout_digits", 32'(digits), 32'h8FED);
    check("timeout_blank", 32'(digit_blank), 32'd0);
    f0 = frames_seen;
    push(16'h3210, 4'hF, 4'h0);
    frame(7'h40, 7'h79, 7'h24, 7'h30);
    check("recover_frame_count", 32'(frames_seen - f0), 32'd1);
    check("recover_stale", 32'(stale), 32'd0);

    // Reset after two captures discards them
    scan(4'hE, 7'h40, 8);
    scan(4'hD, 7'h79, 8);
    rst_n = 1'b0;
    an    = 4'hF;
    seg   = 7'h7F;
    repeat (2) @(negedge clk);
    check("midrst_digits", 32'(digits), 32'd0);
    check("midrst_valid", 32'(digit_valid), 32'd0);
    check("midrst_blank", 32'(digit_blank), 32'd0);
    check("midrst_stale", 32'(stale), 32'd0);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    f0 = frames_seen;
    scan(4'hE, 7'h78, 8);
    scan(4'hD, 7'h00, 8);
    scan(4'hF, 7'h7F, 4);
    check("midrst_partial_no_frame", 32'(frames_seen - f0), 32'd0);
    push(16'hA987, 4'hF, 4'h0);
    scan(4'hB, 7'h18, 8);
    scan(4'h7, 7'h08, 8);
    scan(4'hF, 7'h7F, 4);
    check("midrst_frame_count", 32'(frames_seen - f0), 32'd1);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("pat_err_total", 32'(pat_cycles), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
